// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset vector,
// FSM state encoding and the buffered fetch-entry type.
package ifu_pkg;

    localparam int unsigned          IFU_XLEN     = 64;
    localparam logic [IFU_XLEN-1:0]  IFU_RESET_PC = 64'h8000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [IFU_XLEN-1:0] pc;
        logic [31:0]         inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module ifu_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full     = (count_q == (PW+1)'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        // Pointers are PW bits wide, so wrap modulo DEPTH comes for free.
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        pop_data = mem_q[rd_ptr_q];
        count    = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues 8-byte memory reads, extracts 32-bit
// instructions into a decode buffer, handles redirects, halt and late responses.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = IFU_XLEN,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            halted
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic            osd_push, osd_pop, osd_flush, osd_full, osd_empty;
    logic [XLEN-1:0] osd_head_pc;
    logic [CW-1:0]   osd_count;

    logic            buf_push, buf_pop, buf_flush, buf_full, buf_empty;
    fetch_entry_t    buf_in, buf_out;
    logic [CW-1:0]   buf_count;

    logic            redirect_take, req_fire;
    logic [XLEN-1:0] redirect_tgt;
    logic [CW:0]     inflight, owed, owed_left;

    always_comb begin
        redirect_tgt  = redirect_pc & ~XLEN'(3);
        // Redirects are only honoured in RUN; once a stop is committed it sticks.
        redirect_take = redirect_valid && (state_q == ST_RUN) && !reset;
        // Dropped-but-owed responses still occupy space, so they count as in flight.
        inflight      = {1'b0, osd_count} + {1'b0, buf_count} + {1'b0, drop_cnt_q};
        mem_req_valid = !reset && (state_q == ST_RUN) && !redirect_valid &&
                        (pc_q != '0) && !osd_full && !buf_full &&
                        (inflight < (CW+1)'(DEPTH));
        mem_req_addr  = pc_q & ~XLEN'(7);
        req_fire      = mem_req_valid && mem_req_ready;

        osd_flush  = reset || redirect_take;
        buf_flush  = reset || redirect_take;
        osd_push   = req_fire;
        osd_pop    = 1'b0;
        buf_push   = 1'b0;
        buf_in     = '0;
        drop_cnt_d = drop_cnt_q;
        owed       = {1'b0, drop_cnt_q} + {1'b0, osd_count};
        owed_left  = owed - {{CW{1'b0}}, (mem_rsp_valid && (owed != '0))};

        if (reset || redirect_take) begin
            drop_cnt_d = CW'(owed_left);
        end else if (mem_rsp_valid) begin
            if (drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end else if (!osd_empty) begin
                osd_pop     = 1'b1;
                buf_push    = 1'b1;
                buf_in.pc   = IFU_XLEN'(osd_head_pc);
                buf_in.inst = osd_head_pc[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0];
            end
        end

        out_valid = !buf_empty;
        out_inst  = buf_out.inst;
        out_pc    = XLEN'(buf_out.pc);
        buf_pop   = out_valid && out_ready;

        pc_d = pc_q;
        if (reset) begin
            pc_d = RESET_PC;
        end else if (redirect_take) begin
            pc_d = redirect_tgt;
        end else if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end

        state_d = state_q;
        halted  = (state_q == ST_HALT);
        if (reset) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (redirect_take) begin
                        if (redirect_tgt == '0) begin
                            state_d = (drop_cnt_d != '0) ? ST_DRAIN : ST_HALT;
                        end
                    end else if (pc_q == '0) begin
                        state_d = ST_HALT;
                    end
                end
                ST_DRAIN: if (drop_cnt_d == '0) state_d = ST_HALT;
                ST_HALT:  state_d = ST_HALT;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
        drop_cnt_q <= drop_cnt_d;
    end

    ifu_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_osd_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (osd_flush),
        .push      (osd_push),
        .push_data (pc_q),
        .pop       (osd_pop),
        .pop_data  (osd_head_pc),
        .full      (osd_full),
        .empty     (osd_empty),
        .count     (osd_count)
    );

    ifu_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_buf_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (buf_flush),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (buf_pop),
        .pop_data  (buf_out),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a latency-programmable memory model,
// plus a direct check of ifu_fifo full-FIFO push/pop with pointer wrap.
module tb_ifu_fetch;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h8000_0000;

    logic            clk;
    logic            reset;
    logic            mem_req_valid, mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            out_valid, out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            halted;

    logic       f_flush, f_push, f_pop, f_full, f_empty;
    logic [7:0] f_data, f_out;
    logic [2:0] f_count;

    ifu_fetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    ifu_fifo #(.WIDTH(8), .DEPTH(4)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (f_flush),
        .push      (f_push),
        .push_data (f_data),
        .pop       (f_pop),
        .pop_data  (f_out),
        .full      (f_full),
        .empty     (f_empty),
        .count     (f_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [63:0] req_log[$];
    logic [63:0] got_pc[$];
    logic [63:0] got_inst[$];
    int          cyc;
    int          lat;
    bit          req_zero;
    int          n_checks;
    int          n_errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory word at aligned address a: each half encodes its own byte address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [31:0] lo, hi;
        lo = a[31:0] ^ 32'hDEAD_0000;
        hi = (a[31:0] + 32'd4) ^ 32'hDEAD_0000;
        return {hi, lo};
    endfunction

    function automatic logic [63:0] exp_inst(input logic [63:0] pc);
        return {32'h0, pc[31:0] ^ 32'hDEAD_0000};
    endfunction

    function automatic logic [63:0] at64(input logic [63:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return '1;
    endfunction

    task automatic clear_logs();
        req_log.delete();
        got_pc.delete();
        got_inst.delete();
        req_zero = 1'b0;
    endtask

    // One clock: sample handshakes just before the edge, then advance the memory model.
    task automatic tick();
        bit          rf, sf, of;
        logic [63:0] ra;
        #1;
        rf = mem_req_valid && mem_req_ready;
        ra = mem_req_addr;
        sf = mem_rsp_valid;
        of = out_valid && out_ready;
        if (rf) begin
            req_log.push_back(ra);
            if (ra == 64'h0) req_zero = 1'b1;
        end
        if (of) begin
            got_pc.push_back(out_pc);
            got_inst.push_back({32'h0, out_inst});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (sf && pend.size() > 0) pend.delete(0);
        if (rf) pend.push_back('{addr: ra, due: cyc + lat - 1});
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(pend[0].addr);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_logs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_seq [10];
        n_checks = 0; n_errors = 0; cyc = 0; lat = 1;
        reset = 1'b1; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        f_flush = 1'b0; f_push = 1'b0; f_pop = 1'b0; f_data = '0;
        clear_logs();

        // Reset state
        tick();
        tick();
        check_eq("rst_req_valid", mem_req_valid, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_halted", halted, 0);
        reset = 1'b0;
        clear_logs();
        #1;
        check_eq("rst_first_req", mem_req_valid, 1);
        check_eq("rst_first_addr", mem_req_addr, RPC);

        // Latency 1, free-flowing decode
        repeat (20) tick();
        for (int i = 0; i < 6; i++) begin
            check_eq("t1_req_addr", at64(req_log, i), (RPC + 64'(4 * i)) & ~64'h7);
            check_eq("t1_out_pc", at64(got_pc, i), RPC + 64'(4 * i));
            check_eq("t1_out_inst", at64(got_inst, i), exp_inst(RPC + 64'(4 * i)));
        end

        // Decode stalled: exactly DEPTH entries held, then released in order
        out_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        check_eq("t2_req_count", 64'(req_log.size()), 4);
        check_eq("t2_req_valid", mem_req_valid, 0);
        check_eq("t2_out_valid", out_valid, 1);
        check_eq("t2_hold_pc", out_pc, RPC);
        check_eq("t2_hold_inst", {32'h0, out_inst}, exp_inst(RPC));
        check_eq("t2_no_pops", 64'(got_pc.size()), 0);
        out_ready = 1'b1;
        repeat (12) tick();
        for (int i = 0; i < 5; i++) begin
            check_eq("t2_release_pc", at64(got_pc, i), RPC + 64'(4 * i));
        end

        // Latency 3, redirect with two responses owed and one entry buffered
        out_ready = 1'b0; mem_req_ready = 1'b0; lat = 3;
        do_reset();
        repeat (4) tick();
        clear_logs();
        mem_req_ready = 1'b1;
        repeat (3) tick();
        mem_req_ready = 1'b0;
        tick();
        check_eq("t3_pre_out_valid", out_valid, 1);
        check_eq("t3_pre_out_pc", out_pc, RPC);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0102; mem_req_ready = 1'b1;
        #1;
        check_eq("t3_no_req_in_redirect", mem_req_valid, 0);
        tick();
        redirect_valid = 1'b0; out_ready = 1'b1;
        clear_logs();
        #1;
        check_eq("t3_flushed", out_valid, 0);
        check_eq("t3_new_addr", mem_req_addr, 64'h8000_0100);
        repeat (15) tick();
        check_eq("t3_first_pc", at64(got_pc, 0), 64'h8000_0100);
        check_eq("t3_first_inst", at64(got_inst, 0), exp_inst(64'h8000_0100));
        check_eq("t3_second_pc", at64(got_pc, 1), 64'h8000_0104);
        check_eq("t3_first_req", at64(req_log, 0), 64'h8000_0100);

        // Redirect to 0 while responses are owed: DRAIN, then sticky HALT
        redirect_valid = 1'b1; redirect_pc = 64'h0;
        tick();
        redirect_valid = 1'b0;
        clear_logs();
        #1;
        check_eq("t4_drain_not_halted", halted, 0);
        check_eq("t4_drain_no_req", mem_req_valid, 0);
        repeat (8) tick();
        check_eq("t4_halted", halted, 1);
        check_eq("t4_halt_no_req", mem_req_valid, 0);
        check_eq("t4_no_addr0", {63'h0, req_zero}, 0);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        repeat (5) tick();
        check_eq("t4_still_halted", halted, 1);
        check_eq("t4_ignored_redirect", 64'(req_log.size()), 0);

        // Reset with three requests outstanding: late responses must be dropped
        mem_req_ready = 1'b0;
        do_reset();
        repeat (4) tick();
        clear_logs();
        check_eq("t5_unhalted", halted, 0);
        mem_req_ready = 1'b1;
        repeat (3) tick();
        check_eq("t5_outstanding", 64'(req_log.size()), 3);
        do_reset();
        repeat (12) tick();
        check_eq("t5_first_pc", at64(got_pc, 0), RPC);
        check_eq("t5_first_inst", at64(got_inst, 0), exp_inst(RPC));
        check_eq("t5_second_pc", at64(got_pc, 1), RPC + 64'h4);

        // FIFO: fill, then simultaneous push/pop while full across pointer wrap
        exp_seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        for (int i = 0; i < 4; i++) begin
            f_push = 1'b1; f_data = 8'h10 + 8'(i);
            tick();
        end
        f_push = 1'b0;
        #1;
        check_eq("t6_fill_count", 64'(f_count), 4);
        check_eq("t6_full", f_full, 1);
        for (int i = 0; i < 6; i++) begin
            f_push = 1'b1; f_pop = 1'b1; f_data = 8'h20 + 8'(i);
            #1;
            check_eq("t6_pushpop_data", 64'(f_out), 64'(exp_seq[i]));
            tick();
            check_eq("t6_pushpop_count", 64'(f_count), 4);
        end
        f_push = 1'b0;
        for (int i = 6; i < 10; i++) begin
            #1;
            check_eq("t6_drain_data", 64'(f_out), 64'(exp_seq[i]));
            tick();
        end
        f_pop = 1'b0;
        #1;
        check_eq("t6_empty", f_empty, 1);
        f_push = 1'b1; f_data = 8'h77;
        tick();
        f_push = 1'b0; f_flush = 1'b1;
        tick();
        f_flush = 1'b0;
        check_eq("t6_flush_empty", f_empty, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
